cs_rr_scheduler: RTL and testbench

CS_RR_SCHEDULER -- requirements
Module: cs_rr_scheduler

---
 rtl/cs_rr_scheduler.sv | 131 +++++++++++++
 tb/tb_cs_rr_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cs_rr_scheduler.sv
// rtl/cs_rr_scheduler.sv - round-robin grant scheduler driving a 3-to-8 decoder select/enable
module cs_rr_scheduler #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] iReq,
    output logic [2:0] oSel,
    output logic [1:0] oEna,
    output logic [7:0] oGnt,
    output logic       oBusy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] GAP_INIT  = 4'(GAP_CYCLES - 1);
    localparam logic [1:0] ENA_ON    = 2'b10;
    localparam logic [1:0] ENA_OFF   = 2'b00;

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [1:0] ena_q, ena_d;
    logic [7:0] gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] gap_q, gap_d;

    logic       win_valid;
    logic [2:0] win_idx;
    logic [2:0] probe;
    logic       do_grant;

    // Search ptr+1 .. ptr+8; the last probe wraps back onto ptr itself.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = ptr_q;
        probe     = ptr_q;
        for (int i = 1; i <= 8; i++) begin
            probe = ptr_q + 3'(i);
            if (!win_valid && iReq[probe]) begin
                win_valid = 1'b1;
                win_idx   = probe;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        ena_d    = ena_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        do_grant = 1'b0;
        case (state_q)
            S_IDLE: begin
                do_grant = win_valid;
            end
            S_GRANT: begin
                if (!iReq[sel_q] || hold_q == 4'd0) begin
                    state_d = S_GAP;
                    ena_d   = ENA_OFF;
                    gnt_d   = 8'h00;
                    ptr_d   = sel_q;
                    gap_d   = GAP_INIT;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    do_grant = win_valid;
                    if (!win_valid) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ena_d   = ENA_OFF;
                gnt_d   = 8'h00;
            end
        endcase
        if (do_grant) begin
            state_d = S_GRANT;
            sel_d   = win_idx;
            ena_d   = ENA_ON;
            gnt_d   = 8'b1 << win_idx;
            hold_d  = HOLD_INIT;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 3'd0;
            ena_q   <= ENA_OFF;
            gnt_q   <= 8'h00;
            busy_q  <= 1'b0;
            ptr_q   <= 3'd7;
            hold_q  <= 4'd0;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ena_q   <= ena_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
        end
    end

    assign oSel  = sel_q;
    assign oEna  = ena_q;
    assign oGnt  = gnt_q;
    assign oBusy = busy_q;

endmodule

// File: tb/tb_cs_rr_scheduler.sv
// tb/tb_cs_rr_scheduler.sv - scoreboard bench for cs_rr_scheduler
module tb_cs_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] iReq;
    logic [2:0] oSel;
    logic [1:0] oEna;
    logic [7:0] oGnt;
    logic       oBusy;

    cs_rr_scheduler #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iReq  (iReq),
        .oSel  (oSel),
        .oEna  (oEna),
        .oGnt  (oGnt),
        .oBusy (oBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int len;
        int gap;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    bit   in_grant = 1'b0;
    int   cur_idx  = 0;
    int   cur_len  = 0;
    int   cur_gap  = 0;
    int   idle_cnt = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_assert++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input int i, input int l, input int g);
        exp_t e;
        e.idx = i;
        e.len = l;
        e.gap = g;
        sb.push_back(e);
    endtask

    // Grant tracker: each completed grant is scored against the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            in_grant = 1'b0;
            idle_cnt = 0;
        end else begin
            chk("ena_legal", int'(oEna == 2'b10 || oEna == 2'b00), 1);
            chk("gnt_vs_sel", int'(oGnt), (oEna == 2'b10) ? int'(8'b1 << oSel) : 0);
            if (oEna == 2'b10) begin
                chk("busy_in_grant", int'(oBusy), 1);
                if (!in_grant) begin
                    in_grant = 1'b1;
                    cur_idx  = int'(oSel);
                    cur_len  = 1;
                    cur_gap  = idle_cnt;
                end else begin
                    chk("sel_stable", int'(oSel), cur_idx);
                    cur_len++;
                end
            end else begin
                if (in_grant) begin
                    in_grant = 1'b0;
                    idle_cnt = 0;
                    if (sb.size() == 0) begin
                        chk("unexpected_grant", cur_idx, -1);
                    end else begin
                        e = sb.pop_front();
                        chk("grant_idx", cur_idx, e.idx);
                        chk("grant_len", cur_len, e.len);
                        if (e.gap >= 0) chk("gap_len", cur_gap, e.gap);
                    end
                end
                idle_cnt++;
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", int'(sb.size()), 0);
        iReq = 8'h00;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((oBusy || in_grant) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("idle_busy", int'(oBusy), 0);
    endtask

    task automatic wait_grant();
        int n = 0;
        @(negedge clk);
        while (oEna != 2'b10 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("grant_timeout", int'(oEna), 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        iReq  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_sel", int'(oSel), 0);
        chk("rst_ena", int'(oEna), 0);
        chk("rst_gnt", int'(oGnt), 0);
        chk("rst_busy", int'(oBusy), 0);

        // Fairness: all requesting from reset, index 0 first.
        iReq = 8'hFF;
        push(0, 4, -1);
        for (int i = 1; i < 8; i++) push(i, 4, 1);
        push(0, 4, 1);
        #1 rst_n = 1'b1;
        drain();
        wait_idle();

        // Single requester repeatedly regranted after one gap cycle.
        push(3, 4, -1);
        push(3, 4, 1);
        push(3, 4, 1);
        iReq = 8'h08;
        drain();
        wait_idle();

        // Wrap: 7 then 0 then 7.
        push(7, 4, -1);
        push(0, 4, 1);
        push(7, 4, 1);
        iReq = 8'h81;
        drain();
        wait_idle();

        // Early release after the second grant cycle.
        push(5, 2, -1);
        iReq = 8'h20;
        wait_grant();
        @(negedge clk);
        #1 iReq = 8'h00;
        @(negedge clk);
        chk("early_gap_ena", int'(oEna), 0);
        chk("early_gap_busy", int'(oBusy), 1);
        wait_idle();
        chk("early_drained", int'(sb.size()), 0);

        // Pointer left at 5: 6 wins, then 0, then 5.
        push(6, 4, -1);
        push(0, 4, 1);
        push(5, 4, 1);
        iReq = 8'h61;
        drain();
        wait_idle();

        // Idle return then one-cycle grant latency; other bits toggle mid-grant.
        push(4, 4, -1);
        @(negedge clk);
        #1 iReq = 8'h10;
        #3 chk("lat_before_edge", int'(oEna), 0);
        @(negedge clk);
        chk("lat_ena", int'(oEna), 2);
        chk("lat_sel", int'(oSel), 4);
        #1 iReq = 8'h1F;
        @(negedge clk);
        #1 iReq = 8'h13;
        @(negedge clk);
        #1 iReq = 8'h10;
        drain();
        wait_idle();

        // Asynchronous reset during an active grant.
        iReq = 8'hFF;
        wait_grant();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ena", int'(oEna), 0);
        chk("arst_gnt", int'(oGnt), 0);
        chk("arst_busy", int'(oBusy), 0);
        chk("arst_sel", int'(oSel), 0);
        @(negedge clk);
        push(0, 4, -1);
        #1 rst_n = 1'b1;
        drain();
        wait_idle();

        repeat (3) @(negedge clk);
        chk("final_queue", int'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
